// File: rtl/eth_pkg.sv
// Shared types and constants for the MMIO Ethernet transmit MAC.
package eth_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_SFD,
    ST_DATA,
    ST_PAD,
    ST_FCS,
    ST_IFG
  } tx_state_t;

  localparam logic [3:0] REG_CTRL   = 4'h0;
  localparam logic [3:0] REG_STATUS = 4'h4;
  localparam logic [3:0] REG_LEN    = 4'h8;
  localparam logic [3:0] REG_DATA   = 4'hC;

  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE      = 8'hD5;

  localparam logic [31:0] CRC_POLY = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;

  // One byte of reflected CRC-32, LSB of the byte first.
  function automatic logic [31:0] crc32_next(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'h0, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/eth_crc32.sv
// Byte-wide Ethernet CRC-32 accumulator; fcs is the inverted running value.
module eth_crc32
  import eth_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        enable,
  input  logic [7:0]  data,
  output logic [31:0] fcs
);

  logic [31:0] crc;

  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      crc <= CRC_INIT;
    end else if (enable) begin
      crc <= crc32_next(crc, data);
    end
  end

  assign fcs = ~crc;

endmodule

// File: rtl/eth_tx_mac_mmio.sv
// MMIO-loaded Ethernet transmit MAC: preamble, SFD, payload, pad, FCS, IFG.
// Define ETH_TX_FCS_EN to append the CRC-32 frame check sequence.
module eth_tx_mac_mmio
  import eth_pkg::*;
#(
  parameter int          BUF_WORDS   = 32,
  parameter int          MIN_PAYLOAD = 46,
  parameter int          IFG_CYCLES  = 12,
  parameter logic [31:0] BASE_ADDR   = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] cpu_address,
  input  logic [31:0] cpu_write_data,
  input  logic        cpu_write_enable,
  output logic [31:0] cpu_read_data,
  output logic        phy_tx_ena,
  output logic [7:0]  phy_tx_data
);

  localparam int BYTES = 4 * BUF_WORDS;
  localparam int BW    = $clog2(BYTES);
  localparam logic [BW:0]  CAPACITY = (BW + 1)'(BYTES);
  localparam logic [15:0]  MIN_LEN  = 16'(MIN_PAYLOAD);
  localparam logic [7:0]   IFG_LAST = 8'(IFG_CYCLES - 1);

  tx_state_t   state;
  logic        go;
  logic [15:0] len, xfer_len, pay_cnt;
  logic [7:0]  step_cnt;
  logic        done, overflow, start_err;
  logic [BW:0] loaded;
  logic [BW-1:0] rd_ptr;
  logic [1:0]  rd_sel;
  logic [31:0] rd_word;
  logic [31:0] mem [BUF_WORDS];

  logic       hit, wr_ctrl, wr_status, wr_len, wr_data;
  logic [3:0] off;
  logic       busy, start_req, start_ok, push_ok, push_bad, frame_end;
  logic [7:0] rd_byte;
  logic       unused;

  assign unused    = ^cpu_address[1:0];
  assign hit       = (cpu_address[31:4] == BASE_ADDR[31:4]);
  assign off       = {cpu_address[3:2], 2'b00};
  assign wr_ctrl   = cpu_write_enable && hit && (off == REG_CTRL);
  assign wr_status = cpu_write_enable && hit && (off == REG_STATUS);
  assign wr_len    = cpu_write_enable && hit && (off == REG_LEN);
  assign wr_data   = cpu_write_enable && hit && (off == REG_DATA);

  // busy covers the one cycle between an accepted start and leaving IDLE
  assign busy      = (state != ST_IDLE) || go;
  assign start_req = wr_ctrl && cpu_write_data[0];
  assign start_ok  = start_req && !busy && (len != 16'd0) && (len <= 16'(loaded));
  assign push_ok   = wr_data && !busy && (loaded != CAPACITY);
  assign push_bad  = wr_data && !push_ok;
  assign frame_end = (state == ST_IFG) && (step_cnt == IFG_LAST);
  assign rd_byte   = rd_word[{rd_sel, 3'b000} +: 8];

`ifdef ETH_TX_FCS_EN
  logic [31:0] fcs;
  localparam tx_state_t AFTER_PAYLOAD = ST_FCS;

  eth_crc32 u_crc (
    .clk    (clk),
    .reset  (reset),
    .clear  (state == ST_SFD),
    .enable ((state == ST_DATA) || (state == ST_PAD)),
    .data   ((state == ST_DATA) ? rd_byte : 8'h00),
    .fcs    (fcs)
  );
`else
  localparam tx_state_t AFTER_PAYLOAD = ST_IFG;
`endif

  // Frame buffer: synchronous write and read, no reset needed.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[loaded[BW-1:2]] <= cpu_write_data;
    end
    rd_word <= mem[rd_ptr[BW-1:2]];
    rd_sel  <= rd_ptr[1:0];
  end

  // rd_ptr runs one byte ahead of the byte being launched.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= ST_IDLE;
      go          <= 1'b0;
      xfer_len    <= 16'd0;
      pay_cnt     <= 16'd0;
      step_cnt    <= 8'd0;
      rd_ptr      <= '0;
      phy_tx_ena  <= 1'b0;
      phy_tx_data <= 8'h00;
    end else begin
      phy_tx_ena  <= 1'b0;
      phy_tx_data <= 8'h00;
      if (start_ok) begin
        go       <= 1'b1;
        xfer_len <= len;
      end
      case (state)
        ST_IDLE: begin
          rd_ptr <= '0;
          if (go) begin
            go       <= 1'b0;
            step_cnt <= 8'd0;
            state    <= ST_PRE;
          end
        end
        ST_PRE: begin
          phy_tx_ena  <= 1'b1;
          phy_tx_data <= PREAMBLE_BYTE;
          step_cnt    <= step_cnt + 8'd1;
          if (step_cnt == 8'd6) state <= ST_SFD;
        end
        ST_SFD: begin
          phy_tx_ena  <= 1'b1;
          phy_tx_data <= SFD_BYTE;
          rd_ptr      <= rd_ptr + BW'(1);
          pay_cnt     <= 16'd0;
          state       <= ST_DATA;
        end
        ST_DATA: begin
          phy_tx_ena  <= 1'b1;
          phy_tx_data <= rd_byte;
          rd_ptr      <= rd_ptr + BW'(1);
          pay_cnt     <= pay_cnt + 16'd1;
          if (pay_cnt == xfer_len - 16'd1) begin
            step_cnt <= 8'd0;
            state    <= (xfer_len < MIN_LEN) ? ST_PAD : AFTER_PAYLOAD;
          end
        end
        ST_PAD: begin
          phy_tx_ena <= 1'b1;
          pay_cnt    <= pay_cnt + 16'd1;
          if (pay_cnt == MIN_LEN - 16'd1) begin
            step_cnt <= 8'd0;
            state    <= AFTER_PAYLOAD;
          end
        end
`ifdef ETH_TX_FCS_EN
        ST_FCS: begin
          phy_tx_ena  <= 1'b1;
          phy_tx_data <= fcs[{step_cnt[1:0], 3'b000} +: 8];
          step_cnt    <= step_cnt + 8'd1;
          if (step_cnt == 8'd3) begin
            step_cnt <= 8'd0;
            state    <= ST_IFG;
          end
        end
`endif
        ST_IFG: begin
          step_cnt <= step_cnt + 8'd1;
          if (frame_end) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Hardware set of a sticky bit wins over a same-cycle W1C.
  always_ff @(posedge clk) begin
    if (!reset) begin
      len       <= 16'd0;
      loaded    <= '0;
      done      <= 1'b0;
      overflow  <= 1'b0;
      start_err <= 1'b0;
    end else begin
      if (wr_len) len <= cpu_write_data[15:0];
      if (frame_end) begin
        loaded <= '0;
      end else if (push_ok) begin
        loaded <= loaded + (BW + 1)'(4);
      end
      if (frame_end) done <= 1'b1;
      else if (wr_status && cpu_write_data[1]) done <= 1'b0;
      if (push_bad) overflow <= 1'b1;
      else if (wr_status && cpu_write_data[2]) overflow <= 1'b0;
      if (start_req && !start_ok) start_err <= 1'b1;
      else if (wr_status && cpu_write_data[3]) start_err <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cpu_read_data <= 32'h0;
    end else begin
      cpu_read_data <= 32'h0;
      if (hit) begin
        case (off)
          REG_STATUS: cpu_read_data <= {16'(loaded), 12'h0, start_err, overflow, done, busy};
          REG_LEN:    cpu_read_data <= {16'h0, len};
          default:    cpu_read_data <= 32'h0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_eth_tx_mac_mmio.sv
// Directed bench for eth_tx_mac_mmio: PHY byte scoreboard plus register checks.
module tb_eth_tx_mac_mmio;

  localparam logic [31:0] A_CTRL   = 32'h0;
  localparam logic [31:0] A_STATUS = 32'h4;
  localparam logic [31:0] A_LEN    = 32'h8;
  localparam logic [31:0] A_DATA   = 32'hC;
`ifdef ETH_TX_FCS_EN
  localparam int FCS_BYTES = 4;
`else
  localparam int FCS_BYTES = 0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] cpu_address, cpu_write_data, cpu_read_data;
  logic        cpu_write_enable;
  logic        phy_tx_ena;
  logic [7:0]  phy_tx_data;

  logic        ut_clear, ut_en;
  logic [7:0]  ut_data;
  logic [31:0] ut_fcs;

  eth_tx_mac_mmio dut (
    .clk              (clk),
    .reset            (reset),
    .cpu_address      (cpu_address),
    .cpu_write_data   (cpu_write_data),
    .cpu_write_enable (cpu_write_enable),
    .cpu_read_data    (cpu_read_data),
    .phy_tx_ena       (phy_tx_ena),
    .phy_tx_data      (phy_tx_data)
  );

  eth_crc32 u_crc_ut (
    .clk    (clk),
    .reset  (reset),
    .clear  (ut_clear),
    .enable (ut_en),
    .data   (ut_data),
    .fcs    (ut_fcs)
  );

  int tests_run = 0;
  int tests_failed = 0;
  logic [7:0] exp_q[$];
  logic [7:0] mon_exp;
  int run_len = 0;
  int last_run = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // monitor: every byte the PHY sees is popped from the scoreboard
  always @(negedge clk) begin
    if (phy_tx_ena === 1'b1) begin
      run_len++;
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL phy_byte: unexpected byte 0x%02h, none expected", phy_tx_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if (phy_tx_data !== mon_exp) begin
          tests_failed++;
          $display("FAIL phy_byte: got 0x%02h expected 0x%02h", phy_tx_data, mon_exp);
        end
      end
    end else if (run_len != 0) begin
      last_run = run_len;
      run_len = 0;
    end
  end

  // driver tasks: entered and left just after a falling edge
  task automatic cpu_write(input logic [31:0] a, input logic [31:0] d);
    cpu_address = a;
    cpu_write_data = d;
    cpu_write_enable = 1'b1;
    @(negedge clk);
    cpu_write_enable = 1'b0;
  endtask

  task automatic cpu_read(input logic [31:0] a, output logic [31:0] d);
    cpu_address = a;
    cpu_write_enable = 1'b0;
    @(negedge clk);
    d = cpu_read_data;
  endtask

  task automatic read_check(input string name, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] d;
    cpu_read(a, d);
    check(name, d, exp);
  endtask

  task automatic load_bytes(input logic [7:0] first, input int n);
    logic [31:0] word;
    for (int w = 0; w < n / 4; w++) begin
      for (int b = 0; b < 4; b++) word[8*b +: 8] = first + 8'(4 * w + b);
      cpu_write(A_DATA, word);
    end
  endtask

  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    logic fb;
    r = c;
    for (int i = 0; i < 8; i++) begin
      fb = r[0] ^ b[i];
      r = r >> 1;
      if (fb) r = r ^ 32'hEDB88320;
    end
    return r;
  endfunction

  task automatic push_frame(input logic [7:0] first, input int len);
    logic [31:0] crc;
    logic [7:0] b;
    int total;
    crc = 32'hFFFFFFFF;
    total = (len < 46) ? 46 : len;
    for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    for (int i = 0; i < total; i++) begin
      b = (i < len) ? first + 8'(i) : 8'h00;
      exp_q.push_back(b);
      crc = crc_step(crc, b);
    end
    crc = ~crc;
    for (int i = 0; i < FCS_BYTES; i++) exp_q.push_back(crc[8*i +: 8]);
  endtask

  task automatic wait_not_busy(input string name);
    logic [31:0] d;
    int n;
    n = 0;
    d = 32'h1;
    while (d[0] && n < 300) begin
      cpu_read(A_STATUS, d);
      n++;
    end
    if (d[0]) check(name, d, {d[31:1], 1'b0});
  endtask

  initial begin
    int guard;
    cpu_address = 32'h0;
    cpu_write_data = 32'h0;
    cpu_write_enable = 1'b0;
    ut_clear = 1'b0;
    ut_en = 1'b0;
    ut_data = 8'h00;

    repeat (3) @(negedge clk);
    check("reset_ena", {31'h0, phy_tx_ena}, 32'h0);
    check("reset_data", {24'h0, phy_tx_data}, 32'h0);
    check("reset_rdata", cpu_read_data, 32'h0);
    reset = 1'b1;
    @(negedge clk);

    // CRC unit on "123456789"
    ut_clear = 1'b1;
    @(negedge clk);
    ut_clear = 1'b0;
    ut_en = 1'b1;
    for (int i = 0; i < 9; i++) begin
      ut_data = 8'h31 + 8'(i);
      @(negedge clk);
    end
    ut_en = 1'b0;
    check("crc_check_value", ut_fcs, 32'hCBF43926);
    check("crc_byte_order", {ut_fcs[7:0], ut_fcs[15:8], ut_fcs[23:16], ut_fcs[31:24]}, 32'h2639F4CB);

    read_check("status_after_reset", A_STATUS, 32'h0);
    read_check("len_after_reset", A_LEN, 32'h0);

    // 64-byte frame with latency and IFG timing checks
    load_bytes(8'h00, 64);
    cpu_write(A_LEN, 32'd64);
    read_check("status_loaded64", A_STATUS, 32'h0040_0000);
    read_check("len_64", A_LEN, 32'd64);
    push_frame(8'h00, 64);
    cpu_write(A_CTRL, 32'h1);
    @(negedge clk);
    check("latency_n1_idle", {31'h0, phy_tx_ena}, 32'h0);
    @(negedge clk);
    check("latency_n2_first", {31'h0, phy_tx_ena}, 32'h1);
    guard = 0;
    while (phy_tx_ena && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check("frame1_ends", {31'h0, phy_tx_ena}, 32'h0);
    repeat (10) @(negedge clk);
    read_check("ifg_last_busy", A_STATUS, 32'h0040_0001);
    read_check("ifg_done", A_STATUS, 32'h0000_0002);
    check("frame1_len", last_run, 32'(72 + FCS_BYTES));
    cpu_write(A_STATUS, 32'h2);
    read_check("done_w1c", A_STATUS, 32'h0);

    // short frame with pad; DATA and start while busy are ignored
    load_bytes(8'hA0, 12);
    cpu_write(A_LEN, 32'd10);
    push_frame(8'hA0, 10);
    cpu_write(A_CTRL, 32'h1);
    cpu_write(A_DATA, 32'hDEADBEEF);
    cpu_write(A_CTRL, 32'h1);
    wait_not_busy("frame2_timeout");
    check("frame2_len", last_run, 32'(54 + FCS_BYTES));
    read_check("status_after_frame2", A_STATUS, 32'h0000_000E);
    cpu_write(A_STATUS, 32'hE);
    read_check("status_w1c_all", A_STATUS, 32'h0);

    // start errors: LEN = 0 and LEN > loaded
    cpu_write(A_LEN, 32'd0);
    load_bytes(8'h10, 4);
    cpu_write(A_CTRL, 32'h1);
    repeat (3) @(negedge clk);
    read_check("start_err_len0", A_STATUS, 32'h0004_0008);
    cpu_write(A_STATUS, 32'h8);
    read_check("start_err_w1c", A_STATUS, 32'h0004_0000);
    cpu_write(A_LEN, 32'd8);
    cpu_write(A_CTRL, 32'h1);
    repeat (3) @(negedge clk);
    read_check("start_err_len_gt", A_STATUS, 32'h0004_0008);
    cpu_write(A_STATUS, 32'h8);
    read_check("len_8", A_LEN, 32'd8);

    // fill to capacity, then overflow
    load_bytes(8'h14, 124);
    read_check("status_full", A_STATUS, 32'h0080_0000);
    cpu_write(A_DATA, 32'h12345678);
    read_check("status_overflow", A_STATUS, 32'h0080_0004);
    cpu_write(A_STATUS, 32'h4);

    read_check("ctrl_reads_0", A_CTRL, 32'h0);
    read_check("data_reads_0", A_DATA, 32'h0);
    read_check("outside_base", 32'h0000_0108, 32'h0);

    // reset at SFD+5
    cpu_write(A_LEN, 32'd128);
    for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    for (int i = 0; i < 4; i++) exp_q.push_back(8'h10 + 8'(i));
    cpu_write(A_CTRL, 32'h1);
    repeat (13) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset_mid_ena", {31'h0, phy_tx_ena}, 32'h0);
    check("reset_mid_bytes_seen", 32'(exp_q.size()), 32'h0);
    reset = 1'b1;
    @(negedge clk);
    read_check("reset_mid_status", A_STATUS, 32'h0);
    read_check("reset_mid_len", A_LEN, 32'h0);
    repeat (20) @(negedge clk);

    check("scoreboard_empty", 32'(exp_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/eth_tx_mac_mmio.md
# eth_tx_mac_mmio

MMIO-programmed Ethernet transmit MAC and the successor to the fixed-configuration Ethernet controller. The CPU loads one frame into an internal buffer, writes its length, and starts transmission. The block then emits preamble, SFD, payload, zero padding to minimum size, optional FCS, and an inter-frame gap on an 8-bit PHY transmit interface. Buffer depth, minimum payload, gap length, and register base are parameters.

## Interface
- BUF_WORDS, 32: frame buffer depth in 32-bit words (capacity 4*BUF_WORDS bytes, power of two).
- MIN_PAYLOAD, 46: payloads shorter than this are zero-padded up to it.
- IFG_CYCLES, 12: idle cycles enforced after each frame.
- BASE_ADDR, 32'h0: register block base; decode on cpu_address[31:4] == BASE_ADDR[31:4].
- clk  in  1  single clock for all logic; phy_tx_data/phy_tx_ena are launched on it.
- reset  in  1  synchronous, active-low reset.
- cpu_address  in  32  byte address; word select from [3:2].
- cpu_write_data  in  32  write data.
- cpu_write_enable  in  1  one-cycle write strobe.
- cpu_read_data  out  32  registered read data for the address presented in the previous cycle.
- phy_tx_ena  out  1  frame byte valid.
- phy_tx_data  out  8  frame byte.

## Operation
- Registers, by offset:
  - 0x0 CTRL (W): bit0 = start.
  - 0x4 STATUS (R; W1C on sticky bits):
    - [0] busy.
    - [1] done, sticky.
    - [2] overflow, sticky.
    - [3] start_err, sticky.
    - [31:16] bytes loaded.
  - 0x8 LEN (RW): [15:0] payload bytes.
  - 0xC DATA (W): pushes 4 bytes, LSB first.
- DATA write while busy, or when the buffer is full: dropped; sets overflow.
- Start is accepted only when idle and 1 ≤ LEN ≤ bytes loaded. Otherwise the start is ignored and start_err is set.
- FSM states and byte counts:
  - IDLE → PRE: 7 × 0x55.
  - PRE → SFD: 0xD5.
  - SFD → DATA: LEN bytes from buffer.
  - DATA → PAD: 0x00 until payload count = MIN_PAYLOAD; skipped if LEN ≥ MIN_PAYLOAD.
  - PAD → FCS: 4 bytes.
  - FCS → IFG: IFG_CYCLES with phy_tx_ena = 0.
  - IFG → IDLE.
- On entry to IDLE from IFG: done is set, the buffer write pointer and bytes loaded clear, and LEN is retained.
- Byte counter and buffer read pointer are sized from BUF_WORDS. Payload counter is 16 bits; there is no wrap, because LEN is bounded by capacity.
- Unused register offsets read 0. Writes to them have no effect.

## Timing
- Reset values: cpu_read_data = 0, phy_tx_ena = 0, phy_tx_data = 0, all STATUS bits 0, LEN = 0, FSM = IDLE.
- phy_tx_* are registered outputs. For a start write sampled on edge N, the first 0x55 is valid after edge N+2.
- Bytes are contiguous: phy_tx_ena stays high from the first preamble byte through the last FCS byte, with no gaps.
- The buffer is a synchronous-read RAM. Prefetch one byte ahead so DATA follows SFD without a bubble.
- Minimum frame period is (8 + max(LEN,MIN_PAYLOAD) + 4 + IFG_CYCLES) cycles.
- If reset asserts mid-frame: phy_tx_ena = 0 after the next edge, the frame is abandoned, the buffer empties, and done stays 0.
- STATUS W1C write in the same cycle that hardware sets the same bit: the set wins.

## Configuration
- ETH_TX_FCS_EN defined: CRC-32 is computed over payload plus pad and emitted in FCS state.
  - Reflected poly 0xEDB88320, init 0xFFFFFFFF, final inversion.
  - Sent least-significant byte first.
- ETH_TX_FCS_EN undefined: FCS state is removed and PAD/DATA go directly to IFG. The frame is 4 bytes shorter, and the CRC sub-module is not instantiated.

## Structure
- Package eth_pkg holds:
  - the FSM state enum;
  - register offset constants;
  - PREAMBLE_BYTE = 8'h55, SFD_BYTE = 8'hD5;
  - CRC_POLY and CRC_INIT.
- One sub-module, eth_crc32: byte-wide combinational next-CRC with a registered accumulator, clear and enable inputs, and a 32-bit fcs output.

## Test plan
- eth_crc32 alone: feed ASCII "123456789" → fcs = 0xCBF43926, emitted as 26 39 F4 CB.
- Load 64 bytes 0x00..0x3F, LEN = 64, start → 7×0x55, 0xD5, 0x00..0x3F, 4 FCS bytes. phy_tx_ena high for exactly 76 cycles, then 12 idle cycles. done = 1.
- LEN = 10 with 12 bytes loaded → 10 payload bytes then 36 × 0x00 pad. Frame is 58 bytes (54 without ETH_TX_FCS_EN).
- Start with LEN = 0, or LEN > loaded → no phy_tx_ena; start_err = 1, busy = 0. W1C of 0x8 clears start_err.
- Fill the buffer to 4*BUF_WORDS bytes, then do one more DATA write → overflow = 1 and bytes loaded unchanged. Any DATA write or start while busy leaves the in-flight frame bytes unchanged.
- Pull reset low at SFD+5 → phy_tx_ena = 0 after the next edge; STATUS reads 0 and LEN reads 0.
